// File: rtl/ora_misr.sv
// ora_misr - output response analyzer for the LBIST chain.
//
// Compacts one CUT response word per clock into a multiple-input signature
// register (MISR) while the pattern generator runs. When the generator
// raises END (or the pattern budget runs out) the signature is compared
// against a golden value and a sticky PASS/FAIL verdict is reported.
//
// Ports:
//   clk            in   1     system clock, rising edge
//   rst            in   1     synchronous reset, active high
//   END            in   1     generator exhausted; RESPONSE not valid while high
//   RESPONSE       in   BITS  CUT response for the current pattern
//   SIGNATURE      out  BITS  current MISR contents
//   PATTERN_COUNT  out  CW    responses absorbed (capped at MAX_PATTERNS)
//   DONE           out  1     analysis finished, sticky until rst
//   PASS           out  1     DONE and signature matched and no timeout
//   FAIL           out  1     DONE and (signature mismatch or timeout)
//   TIMEOUT        out  1     MAX_PATTERNS absorbed without END
//   o_dbg_state    out  2     FSM state: 0 = COMPRESS, 1 = COMPARE, 2 = DONE
//
// Input handshake: there is no valid/ready pair. Every clock in COMPRESS
// with END low is a valid response beat; END high marks the stream end and
// its accompanying RESPONSE is never absorbed. Inputs are ignored outside
// COMPRESS.

module ora_misr #(
    parameter int              BITS         = 4,
    parameter logic [BITS-1:0] POLY         = 4'b0011,
    parameter logic [BITS-1:0] SEED         = {BITS{1'b0}},
    parameter logic [BITS-1:0] GOLDEN       = 4'h3,
    parameter int              MAX_PATTERNS = 16,
    localparam int             CW           = $clog2(MAX_PATTERNS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            END,
    input  logic [BITS-1:0] RESPONSE,
    output logic [BITS-1:0] SIGNATURE,
    output logic [CW-1:0]   PATTERN_COUNT,
    output logic            DONE,
    output logic            PASS,
    output logic            FAIL,
    output logic            TIMEOUT,
    output logic [1:0]      o_dbg_state
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PATTERNS);

    typedef enum logic [1:0] {
        S_COMPRESS = 2'd0,
        S_COMPARE  = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t          r_state;
    logic [BITS-1:0] r_sig;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_pass;
    logic            r_fail;
    logic            r_timeout;

    state_t          w_state_nxt;
    logic [BITS-1:0] w_sig_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_done_nxt;
    logic            w_pass_nxt;
    logic            w_fail_nxt;
    logic            w_timeout_nxt;

    logic            w_fb;
    logic [BITS-1:0] w_misr;
    logic            w_good;

    // Internal-XOR MISR: shift towards the MSB, fold the outgoing MSB back
    // into the tapped stages, then XOR the response in parallel.
    assign w_fb   = r_sig[BITS-1];
    assign w_misr = {r_sig[BITS-2:0], 1'b0} ^ (POLY & {BITS{w_fb}}) ^ RESPONSE;

    // A timed-out run can never pass, whatever the signature happens to be.
    assign w_good = (r_sig == GOLDEN) & ~r_timeout;

    always_comb begin
        w_state_nxt   = r_state;
        w_sig_nxt     = r_sig;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_COMPRESS: begin
                // END is checked first so a run ending exactly at the budget
                // is a normal end, not a timeout.
                if (END) begin
                    w_state_nxt = S_COMPARE;
                end else if (r_cnt == MAX_CNT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_COMPARE;
                end else begin
                    w_sig_nxt = w_misr;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_COMPARE: begin
                w_pass_nxt  = w_good;
                w_fail_nxt  = ~w_good;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // Verdict holds until reset.
            end
            default: begin
                w_state_nxt = S_COMPRESS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_COMPRESS;
            r_sig     <= SEED;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sig     <= w_sig_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign SIGNATURE     = r_sig;
    assign PATTERN_COUNT = r_cnt;
    assign DONE          = r_done;
    assign PASS          = r_pass;
    assign FAIL          = r_fail;
    assign TIMEOUT       = r_timeout;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ora_misr.sv
module tb_ora_misr;

  localparam int BITS = 4;
  localparam int POLY = 3;
  localparam int SEED = 0;
  localparam int GOLDEN = 3;
  localparam int MAXP = 16;
  localparam int CW = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            tb_end = 1'b0;
  logic [BITS-1:0] tb_resp = '0;
  logic [BITS-1:0] w_sig;
  logic [CW-1:0]   w_cnt;
  logic            w_done, w_pass, w_fail, w_timeout;
  logic [1:0]      w_state;

  ora_misr dut (
    .clk          (clk),
    .rst          (rst),
    .END          (tb_end),
    .RESPONSE     (tb_resp),
    .SIGNATURE    (w_sig),
    .PATTERN_COUNT(w_cnt),
    .DONE         (w_done),
    .PASS         (w_pass),
    .FAIL         (w_fail),
    .TIMEOUT      (w_timeout),
    .o_dbg_state  (w_state)
  );

  int n_vec = 0;
  int n_miss = 0;

  // responses of the current run, in order
  logic [BITS-1:0] resp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // reference model: signature after absorbing the first n responses
  function automatic int fold(int n);
    int s;
    s = SEED;
    for (int i = 0; i < n; i++) begin
      s = ((s * 2) % 16) ^ ((s >= 8) ? POLY : 0) ^ int'(resp_q[i]);
    end
    return s;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_sig, input int e_cnt,
                         input bit e_done, input bit e_pass, input bit e_fail, input bit e_to);
    chk({tag, "_sig"}, 32'(w_sig), 32'(e_sig));
    chk({tag, "_cnt"}, 32'(w_cnt), 32'(e_cnt));
    chk({tag, "_done"}, 32'(w_done), 32'(e_done));
    chk({tag, "_pass"}, 32'(w_pass), 32'(e_pass));
    chk({tag, "_fail"}, 32'(w_fail), 32'(e_fail));
    chk({tag, "_timeout"}, 32'(w_timeout), 32'(e_to));
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input logic [BITS-1:0] r);
    tb_end = e;
    tb_resp = r;
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tb_end = 1'($urandom_range(0, 1));
    tb_resp = BITS'($urandom_range(0, 15));
    tick();
    rst = 1'b0;
    chk_all({tag, "_rst"}, SEED, 0, 0, 0, 0, 0);
    chk({tag, "_rst_state"}, 32'(w_state), 32'd0);
  endtask

  // One complete analysis run over resp_q. With send_end the stream is
  // terminated by END after min(k,MAXP) responses; otherwise END never
  // comes and the budget must expire.
  task automatic run_seq(input string tag, input int k, input bit send_end);
    int  n_abs;
    bit  to;
    bit  good;
    int  sig;
    n_abs = 0;
    do_reset(tag);
    for (int j = 0; j < k && j < MAXP; j++) begin
      drive(1'b0, resp_q[j]);
      n_abs = j + 1;
      chk_all({tag, "_abs"}, fold(n_abs), n_abs, 0, 0, 0, 0);
    end
    to = !send_end;
    drive(send_end, BITS'($urandom_range(0, 15)));
    sig = fold(n_abs);
    chk_all({tag, "_end"}, sig, n_abs, 0, 0, 0, to);
    good = (sig == GOLDEN) && !to;
    drive(1'($urandom_range(0, 1)), BITS'($urandom_range(0, 15)));
    chk_all({tag, "_verdict"}, sig, n_abs, 1, good, !good, to);
    for (int h = 0; h < 3; h++) begin
      drive(1'($urandom_range(0, 1)), BITS'($urandom_range(0, 15)));
      chk_all({tag, "_hold"}, sig, n_abs, 1, good, !good, to);
    end
  endtask

  task automatic rand_resp(input int k);
    resp_q.delete();
    for (int i = 0; i < k; i++) resp_q.push_back(BITS'($urandom_range(0, 15)));
  endtask

  initial begin
    int k;
    tick();
    do_reset("init");

    // 1: 1,1 then END -> signature 3, pass
    resp_q = '{4'h1, 4'h1};
    run_seq("t1", 2, 1'b1);
    chk("t1_sig_const", 32'(w_sig), 32'h3);
    chk("t1_pass_const", 32'(w_pass), 32'd1);

    // 2: single-bit error -> signature 2, fail
    resp_q = '{4'h1, 4'h0};
    run_seq("t2", 2, 1'b1);
    chk("t2_sig_const", 32'(w_sig), 32'h2);
    chk("t2_fail_const", 32'(w_fail), 32'd1);

    // 3: feedback path, aliases onto golden
    resp_q = '{4'h8, 4'h0};
    run_seq("t3", 2, 1'b1);
    chk("t3_sig_const", 32'(w_sig), 32'h3);
    chk("t3_pass_const", 32'(w_pass), 32'd1);

    // 4: END never comes, zero responses -> timeout
    resp_q.delete();
    for (int i = 0; i < 20; i++) resp_q.push_back(4'h0);
    run_seq("t4", 20, 1'b0);
    chk("t4_cnt_const", 32'(w_cnt), 32'd16);
    chk("t4_to_const", 32'(w_timeout), 32'd1);

    // 5: END right after reset -> seed compared
    resp_q.delete();
    run_seq("t5", 0, 1'b1);

    // END exactly at the budget boundary: normal end, no timeout
    rand_resp(MAXP);
    run_seq("edge16", MAXP, 1'b1);

    // 6: reset mid-compress and in DONE
    do_reset("t6a");
    for (int i = 0; i < 5; i++) drive(1'b0, BITS'($urandom_range(1, 15)));
    do_reset("t6_mid");
    resp_q = '{4'h1, 4'h1};
    run_seq("t6b", 2, 1'b1);
    do_reset("t6_done");

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      k = $urandom_range(0, MAXP);
      rand_resp(k);
      run_seq("rnd", k, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      rand_resp(MAXP);
      run_seq("rnd_to", MAXP, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
